band_sampler: RTL and testbench
===============================

// Module: band_sampler
// PURPOSE
//  Taps the processed video stream leaving the image-processing stage (data/vde/hsync/vsync).
//  On one selectable active row per frame, averages RGB over fixed-width pixel windows.
//  Emits one average per window on a valid/ready stream for the resistor band classifier.
//  Passive tap: never stalls or alters the video stream.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line
//  V_ACTIVE  720   active lines per frame
//  WIN       32    pixels per window; power of 2, divides H_ACTIVE (NWIN = H_ACTIVE/WIN)
//  FIFO_D    4     output FIFO depth; power of 2
// PORTS
//  clk       in   1    pixel clock
//  rst       in   1    reset, asynchronous, active-high
//  data_i    in   24   pixel {red[23:16], grn[15:8], blu[7:0]}, valid when vde_i=1
//  vde_i     in   1    active-video enable
//  hsync_i   in   1    horizontal sync, active-high
//  vsync_i   in   1    vertical sync, active-high
//  row_i     in   10   target active row (0..V_ACTIVE-1); sampled at vsync_i rise
//  avg_o     out  24   window average {red, grn, blu}
//  idx_o     out  6    window index 0..NWIN-1
//  vld_o     out  1    avg_o/idx_o valid
//  rdy_i     in   1    consumer ready
//  done_o    out  1    1-cycle pulse: last window of the row pushed
//  ovf_o     out  1    sticky: a window was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: state=IDLE; x, y, accumulators, FIFO pointers = 0; vld_o=0, done_o=0, ovf_o=0; avg_o=0, idx_o=0.
//  Coordinates: x increments on every cycle with vde_i=1 and clears on vde_i fall.
//   y increments on each vde_i fall, saturating at V_ACTIVE-1; clears at vsync_i rise.
//  Row latch: row_q <= row_i at vsync_i rise. row_i >= V_ACTIVE -> no sampling that frame.
//  FSM:
//   IDLE -> WAIT_ROW on vsync_i rise.
//   WAIT_ROW -> SAMPLE when vde_i=1 and y==row_q.
//   SAMPLE: per-channel accumulate, width 8+log2(WIN), no overflow possible.
//    Accumulator loads (does not add to) the pixel on the first pixel of each window.
//    On the pixel with x%WIN==WIN-1, push {sum>>log2(WIN) per channel, x/WIN} into the FIFO.
//   SAMPLE -> DONE after window NWIN-1 is pushed; done_o pulses on that push cycle.
//   Line ends early (vde_i fall with x<H_ACTIVE) -> partial window discarded, no done_o, -> IDLE.
//   DONE -> WAIT_ROW on vsync_i rise.
//   vsync_i rise in any state -> WAIT_ROW, accumulators cleared, FIFO contents kept.
//  Push latency: average enters the FIFO 1 cycle after the last pixel of its window.
//   With an empty FIFO and rdy_i=1, vld_o rises 2 cycles after that pixel.
//  Output handshake: transfer when vld_o & rdy_i.
//   avg_o/idx_o hold stable while vld_o=1 & rdy_i=0. vld_o never drops without a transfer.
//  FIFO: push and pop in the same cycle are both allowed, including when full (count unchanged).
//   Push while full with no pop -> window dropped, ovf_o<=1.
//  ovf_o clears only on rst.
//  Rounding: truncation (floor) only.
//  Reset mid-row: everything returns to reset values; sampling resumes at the next vsync_i rise.
// TESTING
//  1. Row 5, all pixels 0x204080, rdy_i=1:
//     -> 40 outputs avg 0x204080, idx 0..39 in order, one done_o pulse.
//  2. Row 0, pixel red = x%256, grn=blu=0:
//     -> window k red avg = floor(mean(32k..32k+31 mod 256)); idx0 red=15, idx8 red=15 (wrap).
//  3. rdy_i=0 for the whole row:
//     -> FIFO fills to 4 (idx 0..3 held stable), ovf_o=1.
//     -> after rdy_i=1, exactly idx 0..3 delivered.
//  4. row_i=800 (out of range):
//     -> no vld_o, no done_o for the frame; row_i=2 next frame samples normally.
//  5. vde_i drops at x=100 on the target row:
//     -> windows 0..2 emitted, no done_o, window 3 partial data discarded.
//  6. rst asserted mid-window on the target row:
//     -> all outputs 0 at the next edge; no output until the next frame's target row.

Source files
------------

// File: rtl/band_sampler.sv
// Passive tap on the processed video stream: averages RGB over fixed-width pixel
// windows of one selected row per frame and streams the averages out on valid/ready.
module band_sampler #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned WIN      = 32,
    parameter int unsigned FIFO_D   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_i,
    input  logic        vde_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [9:0]  row_i,
    output logic [23:0] avg_o,
    output logic [5:0]  idx_o,
    output logic        vld_o,
    input  logic        rdy_i,
    output logic        done_o,
    output logic        ovf_o
);
    localparam int unsigned NWIN = H_ACTIVE / WIN;
    localparam int unsigned LW   = $clog2(WIN);
    localparam int unsigned AW   = 8 + LW;
    localparam int unsigned XW   = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW   = 10;
    localparam int unsigned PW   = $clog2(FIFO_D);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_ROW, SAMPLE, DONE} state_t;

    state_t          state, state_d;
    logic            vde_q, vsync_q;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [9:0]      row_q;
    logic [AW-1:0]   acc_r, acc_g, acc_b;
    logic [AW-1:0]   sum_r, sum_g, sum_b;
    logic            pend_vld;
    logic [23:0]     pend_avg;
    logic [5:0]      pend_idx;
    logic [23:0]     avg_mem [FIFO_D];
    logic [5:0]      idx_mem [FIFO_D];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_d;
    logic            vs_rise, vde_fall, row_hit, take, first, last, last_win;
    logic            pop, full, push;

    // hsync is not needed: line boundaries come from vde edges
    logic unused_hsync;
    assign unused_hsync = hsync_i;

    assign vs_rise  = vsync_i & ~vsync_q;
    assign vde_fall = vde_q & ~vde_i;
    assign row_hit  = (y == row_q) && (row_q < 10'(V_ACTIVE));
    assign take     = vde_i && !vs_rise && (state == SAMPLE || (state == WAIT_ROW && row_hit));
    assign first    = (x[LW-1:0] == '0);
    assign last     = (x[LW-1:0] == '1);
    assign last_win = last && ((x >> LW) == XW'(NWIN - 1));

    // first pixel of a window loads rather than adds
    always_comb begin
        sum_r = (first ? '0 : acc_r) + AW'(data_i[23:16]);
        sum_g = (first ? '0 : acc_g) + AW'(data_i[15:8]);
        sum_b = (first ? '0 : acc_b) + AW'(data_i[7:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (vs_rise) begin
            state_d = WAIT_ROW;
        end else begin
            case (state)
                IDLE:     state_d = IDLE;
                WAIT_ROW: if (take) state_d = SAMPLE;
                SAMPLE: begin
                    if (take && last_win) state_d = DONE;
                    else if (vde_fall)    state_d = IDLE;
                end
                DONE:     state_d = DONE;
            endcase
        end
    end

    // Coordinates, accumulation and the one-cycle push staging register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vde_q    <= 1'b0;
            vsync_q  <= 1'b0;
            x        <= '0;
            y        <= '0;
            row_q    <= '0;
            acc_r    <= '0;
            acc_g    <= '0;
            acc_b    <= '0;
            pend_vld <= 1'b0;
            pend_avg <= '0;
            pend_idx <= '0;
            done_o   <= 1'b0;
        end else begin
            vde_q   <= vde_i;
            vsync_q <= vsync_i;
            x       <= vde_i ? x + XW'(1) : '0;
            if (vs_rise) begin
                y     <= '0;
                row_q <= row_i;
            end else if (vde_fall && y != YW'(V_ACTIVE - 1)) begin
                y <= y + YW'(1);
            end
            if (vs_rise) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
            end else if (take) begin
                acc_r <= sum_r;
                acc_g <= sum_g;
                acc_b <= sum_b;
            end
            pend_vld <= take && last;
            if (take && last) begin
                pend_avg <= {sum_r[AW-1:LW], sum_g[AW-1:LW], sum_b[AW-1:LW]};
                pend_idx <= 6'(x >> LW);
            end
            done_o <= take && last_win;
        end
    end

    assign pop  = vld_o & rdy_i;
    assign full = (count == CW'(FIFO_D));
    assign push = pend_vld && (!full || pop);

    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + CW'(1);
        else if (!push && pop) count_d = count - CW'(1);
    end

    // Output FIFO; its head drives avg_o/idx_o directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_D; i++) begin
                avg_mem[i] <= '0;
                idx_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_o  <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            if (push) begin
                avg_mem[wr_ptr] <= pend_avg;
                idx_mem[wr_ptr] <= pend_idx;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
            vld_o <= (count_d != '0);
            if (pend_vld && full && !pop) ovf_o <= 1'b1;
        end
    end

    assign avg_o = avg_mem[rd_ptr];
    assign idx_o = idx_mem[rd_ptr];

endmodule

// File: tb/tb_band_sampler.sv
// Randomized bench for band_sampler: drives synthetic video frames and compares the
// average stream against window means computed directly from the driven pixels.
module tb_band_sampler;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int WIN      = 32;
    localparam int FIFO_D   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data_i = '0;
    logic        vde_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
    logic [9:0]  row_i = '0;
    logic [23:0] avg_o;
    logic [5:0]  idx_o;
    logic        vld_o, done_o, ovf_o;
    logic        rdy_i = 1'b0;

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, last_win_cyc = 0;
    int          done_seen = 0, exp_done = 0, n_out = 0, n_pushed = 0;
    bit          stall = 0, force_rdy = 0, lat_chk = 0;
    logic [29:0] exp_q[$];
    logic [23:0] pix [H_ACTIVE];

    band_sampler dut (
        .clk(clk), .rst(rst), .data_i(data_i), .vde_i(vde_i), .hsync_i(hsync_i),
        .vsync_i(vsync_i), .row_i(row_i), .avg_o(avg_o), .idx_o(idx_o), .vld_o(vld_o),
        .rdy_i(rdy_i), .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_i = force_rdy ? 1'b1 : (stall ? 1'b0 : ($urandom_range(3) != 0));
        end
    end

    // Output monitor: scoreboard order, handshake stability, first-output latency
    logic        hold_q = 1'b0, prev_vld = 1'b0;
    logic [29:0] held = '0;
    always @(negedge clk) begin
        logic [29:0] e;
        if (rst) begin
            hold_q   = 1'b0;
            prev_vld = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_vld", 32'(vld_o), 32'd1);
                check("hold_data", 32'({avg_o, idx_o}), 32'(held));
            end
            if (lat_chk && vld_o && !prev_vld)
                check("latency", 32'(cyc - last_win_cyc), 32'd2);
            if (vld_o && rdy_i) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_vld", 32'(vld_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("avg", 32'(avg_o), 32'(e[29:6]));
                    check("idx", 32'(idx_o), 32'(e[5:0]));
                end
            end
            if (done_o) done_seen++;
            hold_q   = vld_o && !rdy_i;
            held     = {avg_o, idx_o};
            prev_vld = vld_o;
        end
    end

    function automatic logic [23:0] gen_pix(input int mode, input int x);
        logic [23:0] p;
        case (mode)
            1:       p = 24'h204080;
            2:       p = {8'(x), 16'h0000};
            default: p = 24'($urandom);
        endcase
        return p;
    endfunction

    task automatic drive_line(input int len, input bit tgt, input int mode, input int rst_at);
        bit samp;
        int sr, sg, sb;
        samp = tgt;
        for (int x = 0; x < len; x++) begin
            step();
            vde_i  = 1'b1;
            data_i = gen_pix(mode, x);
            if (x == rst_at) begin
                rst  = 1'b1;
                samp = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check("rst_vld", 32'(vld_o), 32'd0);
                check("rst_done", 32'(done_o), 32'd0);
                check("rst_ovf", 32'(ovf_o), 32'd0);
                check("rst_avg", 32'(avg_o), 32'd0);
                check("rst_idx", 32'(idx_o), 32'd0);
            end
            if (x == rst_at + 3) rst = 1'b0;
            if (samp) begin
                pix[x] = data_i;
                if (x % WIN == WIN - 1) begin
                    last_win_cyc = cyc;
                    if (!stall || n_pushed < FIFO_D) begin
                        sr = 0; sg = 0; sb = 0;
                        for (int k = x - WIN + 1; k <= x; k++) begin
                            sr += int'(pix[k][23:16]);
                            sg += int'(pix[k][15:8]);
                            sb += int'(pix[k][7:0]);
                        end
                        exp_q.push_back({8'(sr / WIN), 8'(sg / WIN), 8'(sb / WIN), 6'(x / WIN)});
                        n_pushed++;
                    end
                end
                if (x == H_ACTIVE - 1) exp_done++;
            end
        end
        step();
        vde_i  = 1'b0;
        data_i = '0;
        repeat (2) step();
        hsync_i = 1'b1;
        repeat (3) step();
        hsync_i = 1'b0;
        repeat (2) step();
    endtask

    // Non-target lines are kept short; only vde falls matter for row counting
    task automatic run_frame(input int row, input int nlines, input int mode,
                             input int short_len, input int rst_at);
        bit tgt;
        int len;
        done_seen = 0;
        exp_done  = 0;
        n_pushed  = 0;
        step();
        vsync_i = 1'b1;
        row_i   = 10'(row);
        step();
        row_i = 10'($urandom);
        repeat (2) step();
        vsync_i = 1'b0;
        repeat (4) step();
        for (int y = 0; y < nlines; y++) begin
            tgt = (y == row) && (row < V_ACTIVE);
            len = tgt ? ((short_len > 0) ? short_len : H_ACTIVE) : 40;
            drive_line(len, tgt, mode, tgt ? rst_at : -1);
        end
    endtask

    task automatic finish_frame(input bit chk_done, input bit exp_ovf);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (50) step();
        if (chk_done) check("done_cnt", 32'(done_seen), 32'(exp_done));
        check("ovf", 32'(ovf_o), 32'(exp_ovf));
    endtask

    initial begin
        int n0, r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_vld", 32'(vld_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_ovf", 32'(ovf_o), 32'd0);
        check("reset_avg", 32'(avg_o), 32'd0);
        check("reset_idx", 32'(idx_o), 32'd0);
        step();
        rst = 1'b0;

        force_rdy = 1; lat_chk = 1;
        run_frame(5, 7, 1, 0, -1);
        finish_frame(1, 0);
        force_rdy = 0; lat_chk = 0;

        run_frame(0, 2, 2, 0, -1);
        finish_frame(1, 0);

        run_frame(800, 3, 0, 0, -1);
        finish_frame(1, 0);
        run_frame(2, 4, 0, 0, -1);
        finish_frame(1, 0);

        run_frame(1, 3, 0, 100, -1);
        finish_frame(1, 0);

        for (int f = 0; f < 5; f++) begin
            r = $urandom_range(3);
            run_frame(r, r + 2, 0, 0, -1);
            finish_frame(1, 0);
        end

        stall = 1;
        run_frame(0, 2, 0, 0, -1);
        repeat (5) step();
        check("stall_ovf", 32'(ovf_o), 32'd1);
        check("stall_vld", 32'(vld_o), 32'd1);
        check("stall_idx", 32'(idx_o), 32'd0);
        n0 = n_out;
        stall = 0;
        finish_frame(0, 1);
        check("stall_out_cnt", 32'(n_out - n0), 32'(FIFO_D));

        run_frame(1, 3, 0, 0, 50);
        finish_frame(1, 0);
        run_frame(2, 4, 0, 0, -1);
        finish_frame(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
